// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decode/issue register that sits directly in front of the ALU. It decodes
// RV32I OP, OP-IMM, LUI and AUIPC, selects the two ALU operands (with an
// optional writeback bypass), builds the 4-bit ALU control code and holds the
// result in a one-entry pipeline register whose outputs feed the ALU.
//
// Handshake (both sides use strict valid/ready):
//   - A transfer happens on a rising edge when valid and ready are both high.
//   - Upstream: in_valid/in_ready. in_ready = !out_valid | out_ready, so it
//     never depends on in_valid. An accepted word is registered at that edge.
//   - Downstream: out_valid/out_ready. While out_valid & !out_ready every
//     output is frozen. Once out_valid rises it stays high until out_ready
//     (or flush/reset) retires it.
//   - flush drops the held entry and refuses the incoming one; reset beats
//     flush, flush beats in_valid.
//   - Data outputs keep their last value when out_valid falls.
module alu_issue_stage #(
  parameter int XLEN      = 32,   // only 32 is supported
  parameter bit BYPASS_EN = 1'b1  // 1: forward wb_data on a register match
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] srca,
  output logic [XLEN-1:0] srcb,
  output logic [3:0]      ALU_control,
  output logic [4:0]      rd,
  output logic            illegal
);

  // Major opcodes handled here
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 patterns
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 values that need special handling
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [2:0] funct3;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [6:0] funct7;

  assign opcode  = instr[6:0];
  assign rd_f    = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  // Immediates
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt_ext;

  assign imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u     = {instr[31:12], 12'b0};
  assign shamt_ext = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Pipeline register state
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] srca_q,    srca_d;
  logic [XLEN-1:0] srcb_q,    srcb_d;
  logic [3:0]      ctl_q,     ctl_d;
  logic [4:0]      rd_q,      rd_d;
  logic            illegal_q, illegal_d;

  // Handshake
  logic accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Bypass match terms; wb_rd == 0 never forwards because x0 is hardwired.
  logic fwd_rs1;
  logic fwd_rs2;

  assign fwd_rs1 = BYPASS_EN && wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
  assign fwd_rs2 = BYPASS_EN && wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_idx);

  // Effective source register values: x0 reads zero, then bypass, then regfile
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // Resolve source operand values
  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
    if (rs1_idx == 5'd0) begin
      rs1_val = '0;
    end else if (fwd_rs1) begin
      rs1_val = wb_data;
    end
    if (rs2_idx == 5'd0) begin
      rs2_val = '0;
    end else if (fwd_rs2) begin
      rs2_val = wb_data;
    end
  end

  // Decoded operation, before registering
  logic            dec_legal;
  logic [XLEN-1:0] dec_srca;
  logic [XLEN-1:0] dec_srcb;
  logic [3:0]      dec_ctl;

  // Decode opcode/funct fields into operands and ALU code
  always_comb begin
    dec_legal = 1'b0;
    dec_srca  = '0;
    dec_srcb  = '0;
    dec_ctl   = ALU_ADD;
    unique case (opcode)
      OPC_OP: begin
        dec_srca = rs1_val;
        dec_srcb = rs2_val;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_ctl   = {1'b0, funct3};
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          // {1, 000} is re-coded so SUB has its own distinct code
          dec_legal = 1'b1;
          dec_ctl   = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          dec_legal = 1'b1;
          dec_ctl   = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec_srca = rs1_val;
        if (funct3 == F3_SLL) begin
          dec_srcb  = shamt_ext;
          dec_ctl   = ALU_SLL;
          dec_legal = (funct7 == F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          dec_srcb = shamt_ext;
          if (funct7 == F7_BASE) begin
            dec_legal = 1'b1;
            dec_ctl   = ALU_SRL;
          end else if (funct7 == F7_ALT) begin
            dec_legal = 1'b1;
            dec_ctl   = ALU_SRA;
          end
        end else begin
          // Non-shift immediates use funct3 directly (ADDI -> ADD)
          dec_legal = 1'b1;
          dec_srcb  = imm_i;
          dec_ctl   = {1'b0, funct3};
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_srca  = '0;
        dec_srcb  = imm_u;
        dec_ctl   = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_srca  = pc;
        dec_srcb  = imm_u;
        dec_ctl   = ALU_ADD;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Next-state of the pipeline register: flush, load, drain or hold
  always_comb begin
    valid_d   = valid_q;
    srca_d    = srca_q;
    srcb_d    = srcb_q;
    ctl_d     = ctl_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      if (dec_legal) begin
        srca_d    = dec_srca;
        srcb_d    = dec_srcb;
        ctl_d     = dec_ctl;
        rd_d      = rd_f;
        illegal_d = 1'b0;
      end else begin
        // Undecodable words still issue, as a harmless flagged ADD 0+0 -> x0
        srca_d    = '0;
        srcb_d    = '0;
        ctl_d     = ALU_ADD;
        rd_d      = 5'd0;
        illegal_d = 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      srca_q    <= '0;
      srcb_q    <= '0;
      ctl_q     <= ALU_ADD;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      srca_q    <= srca_d;
      srcb_q    <= srcb_d;
      ctl_q     <= ctl_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign srca        = srca_q;
  assign srcb        = srcb_q;
  assign ALU_control = ctl_q;
  assign rd          = rd_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed scenarios plus a randomized run against a behavioural model of the
// issue stage.
module tb_alu_issue_stage;

  localparam int W = 74; // {illegal, rd, ctl, srca, srcb}

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  ALU_control;
  logic [4:0]  rd;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_last;

  alu_issue_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .srca(srca), .srcb(srcb),
    .ALU_control(ALU_control), .rd(rd), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; in_valid = 1'b0; instr = 32'h0; pc = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; wb_valid = 1'b0; wb_rd = 5'd0;
    wb_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdx, input logic [6:0] op);
    return {f7, r2, r1, f3, rdx, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdx);
    return {imm, r1, f3, rdx, 7'h13};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] reg_read(input logic [4:0] idx, input logic [31:0] rf,
                                           input logic wv, input logic [4:0] wrd,
                                           input logic [31:0] wd);
    if (idx == 0) return 32'h0;
    if (wv && wrd == idx) return wd;
    return rf;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [31:0] ins, input logic [31:0] pcv,
                                          input logic [31:0] r1d, input logic [31:0] r2d,
                                          input logic wv, input logic [4:0] wrd,
                                          input logic [31:0] wd);
    logic [31:0] a, b, sa, sb;
    logic signed [11:0] imm12;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] code;
    logic ok;
    a = reg_read(ins[19:15], r1d, wv, wrd, wd);
    b = reg_read(ins[24:20], r2d, wv, wrd, wd);
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    imm12 = ins[31:20];
    ok = 1'b0; sa = 32'h0; sb = 32'h0; code = 4'h0;
    if (op == 7'h33) begin
      sa = a; sb = b;
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      code = (f7 == 7'h20 && f3 == 3'd0) ? 4'b1001 : {f7[5], f3};
    end else if (op == 7'h13) begin
      sa = a;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        sb = {27'h0, ins[24:20]};
        ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        code = {f7[5], f3};
      end else begin
        sb = imm12;
        ok = 1'b1;
        code = {1'b0, f3};
      end
    end else if (op == 7'h37) begin
      sa = 32'h0; sb = ins & 32'hFFFFF000; ok = 1'b1;
    end else if (op == 7'h17) begin
      sa = pcv; sb = ins & 32'hFFFFF000; ok = 1'b1;
    end
    if (!ok) return {1'b1, 5'd0, 4'd0, 32'h0, 32'h0};
    return {1'b0, ins[11:7], code, sa, sb};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    rs1_data = 32'h11; rs2_data = 32'h22;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if ({srca, srcb} !== 64'h0) begin errors++; $display("FAIL reset_src: got %h/%h expected 0/0", srca, srcb); end
    checks++; if ({ALU_control, rd, illegal} !== 10'h0) begin errors++; $display("FAIL reset_ctl: got ctl=%b rd=%0d ill=%b expected 0", ALU_control, rd, illegal); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    do_reset();
    in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    rs1_data = 32'd5; rs2_data = 32'd7;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if (srca !== 32'd5 || srcb !== 32'd7) begin errors++; $display("FAIL add_src: got %h/%h expected 5/7", srca, srcb); end
    checks++; if (ALU_control !== 4'b0000 || rd !== 5'd3 || illegal !== 1'b0) begin errors++; $display("FAIL add_ctl: got ctl=%b rd=%0d ill=%b expected 0000/3/0", ALU_control, rd, illegal); end
    tick();
    checks++; if (out_valid !== 1'b0 || srca !== 32'd5) begin errors++; $display("FAIL add_drain: got v=%b srca=%h expected 0/5", out_valid, srca); end
  endtask

  task automatic test_imm();
    logic [31:0] r;
    do_reset();
    r = $urandom;
    in_valid = 1'b1; instr = 32'h4030D213; rs1_data = r;
    tick();
    checks++; if (srca !== r || srcb !== 32'd3) begin errors++; $display("FAIL srai_src: got %h/%h expected %h/3", srca, srcb, r); end
    checks++; if (ALU_control !== 4'b1101 || rd !== 5'd4 || illegal !== 1'b0) begin errors++; $display("FAIL srai_ctl: got ctl=%b rd=%0d ill=%b expected 1101/4/0", ALU_control, rd, illegal); end
    instr = 32'hFFF00093; rs1_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    checks++; if (srca !== 32'h0 || srcb !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_src: got %h/%h expected 0/ffffffff", srca, srcb); end
    checks++; if (ALU_control !== 4'b0000 || rd !== 5'd1) begin errors++; $display("FAIL addi_ctl: got ctl=%b rd=%0d expected 0000/1", ALU_control, rd); end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    out_ready = 1'b0;
    instr = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd6, 7'h33);
    rs1_data = 32'd9; rs2_data = 32'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || srca !== 32'd5 || srcb !== 32'd7 || ALU_control !== 4'd0 || rd !== 5'd3) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b %h/%h ctl=%b rd=%0d expected 1 5/7 0000 3", i, out_valid, srca, srcb, ALU_control, rd);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || srca !== 32'd9 || srcb !== 32'd10 || ALU_control !== 4'b0100 || rd !== 5'd6) begin
      errors++; $display("FAIL stall_release: got v=%b %h/%h ctl=%b rd=%0d expected 1 9/a 0100 6", out_valid, srca, srcb, ALU_control, rd);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1'b1; instr = enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd5, 7'h33);
    rs1_data = 32'h55; rs2_data = 32'h66;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    tick();
    checks++; if (srca !== 32'h1234 || srcb !== 32'h1234 || ALU_control !== 4'b1001 || rd !== 5'd5) begin
      errors++; $display("FAIL bypass_sub: got %h/%h ctl=%b rd=%0d expected 1234/1234 1001 5", srca, srcb, ALU_control, rd);
    end
    wb_rd = 5'd0;
    tick();
    checks++; if (srca !== 32'h55 || srcb !== 32'h66) begin errors++; $display("FAIL bypass_rd0: got %h/%h expected 55/66", srca, srcb); end
    // rs2-only match, rs1 = x0 ignores regfile data
    instr = enc_r(7'h00, 5'd2, 5'd0, 3'd6, 5'd7, 7'h33); wb_rd = 5'd2; wb_data = 32'hABCD;
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    checks++; if (srca !== 32'h0 || srcb !== 32'hABCD || ALU_control !== 4'b0110) begin
      errors++; $display("FAIL bypass_rs2_x0: got %h/%h ctl=%b expected 0/abcd 0110", srca, srcb, ALU_control);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; flush = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_incoming: got v=%b expected 0", out_valid); end
    flush = 1'b0;
    tick();
    out_ready = 1'b0; flush = 1'b1; rs1_data = 32'd99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || srca !== 32'd5) begin errors++; $display("FAIL flush_held: got v=%b srca=%h expected 0/5", out_valid, srca); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    in_valid = 1'b1; instr = 32'h4030D213; rs1_data = 32'h77;
    tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, srca, srcb, ALU_control, rd, illegal} !== 75'h0) begin
      errors++; $display("FAIL reset_mid_stall: got v=%b %h/%h ctl=%b rd=%0d ill=%b expected all 0", out_valid, srca, srcb, ALU_control, rd, illegal);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    in_valid = 1'b1; instr = 32'h0000007F; rs1_data = 32'h5; rs2_data = 32'h6;
    tick();
    checks++; if (illegal !== 1'b1 || out_valid !== 1'b1 || ALU_control !== 4'd0 || rd !== 5'd0 || srca !== 32'h0 || srcb !== 32'h0) begin
      errors++; $display("FAIL illegal_opcode: got ill=%b v=%b ctl=%b rd=%0d %h/%h expected 1 1 0000 0 0/0", illegal, out_valid, ALU_control, rd, srca, srcb);
    end
    instr = enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd9, 7'h33);
    tick();
    checks++; if (illegal !== 1'b1 || rd !== 5'd0) begin errors++; $display("FAIL illegal_f7_and: got ill=%b rd=%0d expected 1/0", illegal, rd); end
    instr = enc_i({7'h20, 5'd4}, 5'd1, 3'd1, 5'd8);
    tick();
    in_valid = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_slli: got ill=%b expected 1", illegal); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      instr = enc_i(12'(i * 3), 5'd0, 3'd0, 5'(i));
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || srcb !== 32'(i * 3) || rd !== 5'(i)) begin
        errors++; $display("FAIL b2b[%0d]: got v=%b srcb=%h rd=%0d expected 1 %h %0d", i, out_valid, srcb, rd, i * 3, i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] pred;
    logic [W-1:0] obs;
    logic acc, con;
    int sel;
    do_reset();
    exp_q.delete();
    exp_last = '0;
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      wb_valid = $urandom_range(0, 1);
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      instr = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1: instr[6:0] = 7'h33;
        2, 3: instr[6:0] = 7'h13;
        4: instr[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0, 1: instr[31:25] = 7'h00;
        2: instr[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) instr[19:15] = wb_rd;
      if ($urandom_range(0, 2) == 0) instr[24:20] = wb_rd;
      #1;
      checks++; if (in_ready !== ((exp_q.size() == 0) || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", n, in_ready, (exp_q.size() == 0) || out_ready);
      end
      pred = ref_op(instr, pc, rs1_data, rs2_data, wb_valid, wb_rd, wb_data);
      acc = in_valid && !flush && ((exp_q.size() == 0) || out_ready);
      con = (exp_q.size() != 0) && out_ready;
      tick();
      if (reset) begin
        exp_q.delete();
        exp_last = '0;
      end else if (flush) begin
        exp_q.delete();
      end else begin
        if (con) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back(pred);
          exp_last = pred;
        end
      end
      obs = {illegal, rd, ALU_control, srca, srcb};
      checks++; if (out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, exp_q.size() != 0);
      end
      checks++; if (obs !== exp_last) begin
        errors++; $display("FAIL rnd_data[%0d]: got %h expected %h (instr %h)", n, obs, exp_last, instr);
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_imm();
    test_stall();
    test_bypass();
    test_flush();
    test_reset_mid_stall();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
